// File: rtl/grayscale_to_color_stream_if.sv
// ----------------------------------------------------------------------------
// grayscale_to_color_stream_if
//   Pixel stream bundle for the pseudo-colour expander. Carries both sides
//   of the block: the grayscale input stream and the RGB output stream.
//
//   Input side  : in_gray[7:0], in_valid, in_sof, in_mode, in_ready
//   Output side : out_r/out_g/out_b[7:0], out_valid, out_sof, out_eol,
//                 out_eof, out_ready
//
//   slave  : the expander (consumes the gray stream, produces RGB)
//   master : the environment (drives the gray stream, sinks RGB)
// ----------------------------------------------------------------------------
interface grayscale_to_color_stream_if;
    logic [7:0] in_gray;
    logic       in_valid;
    logic       in_sof;
    logic       in_mode;
    logic       in_ready;

    logic [7:0] out_r;
    logic [7:0] out_g;
    logic [7:0] out_b;
    logic       out_valid;
    logic       out_sof;
    logic       out_eol;
    logic       out_eof;
    logic       out_ready;

    modport slave (
        input  in_gray, in_valid, in_sof, in_mode, out_ready,
        output in_ready, out_r, out_g, out_b, out_valid, out_sof, out_eol, out_eof
    );

    modport master (
        output in_gray, in_valid, in_sof, in_mode, out_ready,
        input  in_ready, out_r, out_g, out_b, out_valid, out_sof, out_eol, out_eof
    );
endinterface

// File: rtl/grayscale_to_color_stream.sv
// ----------------------------------------------------------------------------
// grayscale_to_color_stream
//   Streaming pseudo-colour expander. Turns an 8-bit grayscale pixel stream
//   into 24-bit RGB, either by replicating the gray value (mode 0) or through
//   a 4-segment heat map (mode 1). Tracks the frame position of every input
//   beat and attaches end-of-line / end-of-frame markers to the output.
//
//   Ports
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     px_if      pixel stream bundle (slave side), see the interface file
//     frame_err  sticky: a start-of-frame arrived while not at (0,0)
//
//   Pipeline: stage 1 registers gray/segment/mode/flags, stage 2 registers
//   the mapped RGB and flags and drives the outputs directly. Both stages
//   advance whenever the stage after them can take data, so the block runs
//   at one pixel per clock with two cycles of latency.
// ----------------------------------------------------------------------------
module grayscale_to_color_stream #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                         clk,
    input  logic                         rst,
    grayscale_to_color_stream_if.slave   px_if,
    output logic                         frame_err
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // stage 1
    logic          s1_valid_q;
    logic [7:0]    s1_gray_q;
    logic [1:0]    s1_seg_q;
    logic          s1_mode_q;
    logic          s1_sof_q;
    logic          s1_eol_q;
    logic          s1_eof_q;

    // stage 2 (output registers)
    logic          s2_valid_q;
    logic [7:0]    s2_r_q;
    logic [7:0]    s2_g_q;
    logic [7:0]    s2_b_q;
    logic          s2_sof_q;
    logic          s2_eol_q;
    logic          s2_eof_q;

    // frame state
    logic          mode_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          frame_err_q;

    logic          s2_load;
    logic          s1_load;
    logic          in_xfer;

    logic          eff_mode;
    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;
    logic          pos_eol;
    logic          pos_eof;
    logic [CW-1:0] col_d;
    logic [RW-1:0] row_d;
    logic          sof_mid_frame;

    logic [7:0]    x4;
    logic [7:0]    r_d;
    logic [7:0]    g_d;
    logic [7:0]    b_d;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign s2_load = !s2_valid_q || px_if.out_ready;
    assign s1_load = !s1_valid_q || s2_load;
    assign in_xfer = px_if.in_valid && s1_load;

    // ------------------------------------------------------------------------
    // Frame position of the incoming beat. A sof beat is always placed at
    // (0,0), even mid-frame, so the stream resynchronises on it.
    // ------------------------------------------------------------------------
    always_comb begin
        eff_mode      = px_if.in_sof ? px_if.in_mode : mode_q;
        pos_col       = px_if.in_sof ? '0 : col_q;
        pos_row       = px_if.in_sof ? '0 : row_q;
        pos_eol       = (pos_col == COL_LAST);
        pos_eof       = pos_eol && (pos_row == ROW_LAST);
        sof_mid_frame = px_if.in_sof && ((col_q != '0) || (row_q != '0));

        col_d = pos_col + 1'b1;
        row_d = pos_row;
        if (pos_eol) begin
            col_d = '0;
            row_d = pos_eof ? '0 : (pos_row + 1'b1);
        end
    end

    // ------------------------------------------------------------------------
    // Colour mapping from stage 1 into stage 2.
    // 255 - v equals ~v for 8-bit v, so the falling ramps are a plain invert.
    // ------------------------------------------------------------------------
    always_comb begin
        x4  = {s1_gray_q[5:0], 2'b00};
        r_d = s1_gray_q;
        g_d = s1_gray_q;
        b_d = s1_gray_q;
        if (s1_mode_q) begin
            case (s1_seg_q)
                2'd0: begin
                    r_d = 8'h00;
                    g_d = x4;
                    b_d = 8'hFF;
                end
                2'd1: begin
                    r_d = 8'h00;
                    g_d = 8'hFF;
                    b_d = ~x4;
                end
                2'd2: begin
                    r_d = x4;
                    g_d = 8'hFF;
                    b_d = 8'h00;
                end
                default: begin
                    r_d = 8'hFF;
                    g_d = ~x4;
                    b_d = 8'h00;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_gray_q   <= '0;
            s1_seg_q    <= '0;
            s1_mode_q   <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_r_q      <= '0;
            s2_g_q      <= '0;
            s2_b_q      <= '0;
            s2_sof_q    <= 1'b0;
            s2_eol_q    <= 1'b0;
            s2_eof_q    <= 1'b0;
            mode_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_xfer;
                if (in_xfer) begin
                    s1_gray_q <= px_if.in_gray;
                    s1_seg_q  <= px_if.in_gray[7:6];
                    s1_mode_q <= eff_mode;
                    s1_sof_q  <= px_if.in_sof;
                    s1_eol_q  <= pos_eol;
                    s1_eof_q  <= pos_eof;
                end
            end

            // Stage 2 data only changes when a real beat moves in, so the
            // outputs stay put while stalled or idle.
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_r_q   <= r_d;
                    s2_g_q   <= g_d;
                    s2_b_q   <= b_d;
                    s2_sof_q <= s1_sof_q;
                    s2_eol_q <= s1_eol_q;
                    s2_eof_q <= s1_eof_q;
                end
            end

            if (in_xfer) begin
                mode_q <= eff_mode;
                col_q  <= col_d;
                row_q  <= row_d;
                if (sof_mid_frame) begin
                    frame_err_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign px_if.in_ready  = s1_load;
    assign px_if.out_valid = s2_valid_q;
    assign px_if.out_r     = s2_r_q;
    assign px_if.out_g     = s2_g_q;
    assign px_if.out_b     = s2_b_q;
    assign px_if.out_sof   = s2_sof_q;
    assign px_if.out_eol   = s2_eol_q;
    assign px_if.out_eof   = s2_eof_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_grayscale_to_color_stream.sv
// ----------------------------------------------------------------------------
// tb_grayscale_to_color_stream
//   Directed bench for the pseudo-colour expander, built with a 4x2 frame so
//   line and frame markers show up often. Every accepted input beat pushes
//   its expected RGB/flags (and acceptance cycle) into a queue; the output
//   monitor pops and compares on each output transfer and checks that the
//   outputs hold while stalled.
// ----------------------------------------------------------------------------
module tb_grayscale_to_color_stream;

    localparam int W = 4;
    localparam int H = 2;

    typedef struct {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
        logic        eof;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic frame_err;

    grayscale_to_color_stream_if px_if();

    grayscale_to_color_stream #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .px_if     (px_if),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    // reference frame state
    int   m_col  = 0;
    int   m_row  = 0;
    logic m_mode = 1'b0;

    int   bp_mode = 0;        // 0: out_ready=1, 1: random, 2: out_ready=0
    logic lat_chk = 1'b1;
    int   n_out = 0, n_sof = 0, n_eol = 0, n_eof = 0, last_eol_idx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [23:0] map_ref(input logic [7:0] g, input logic md);
        int q;
        q = int'(g[5:0]) * 4;
        if (!md) return {g, g, g};
        case (g[7:6])
            2'd0:    return {8'd0, 8'(q), 8'd255};
            2'd1:    return {8'd0, 8'd255, 8'(255 - q)};
            2'd2:    return {8'(q), 8'd255, 8'd0};
            default: return {8'd255, 8'(255 - q), 8'd0};
        endcase
    endfunction

    // out_ready driver
    initial begin
        px_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       px_if.out_ready = 1'b1;
                1:       px_if.out_ready = 1'($urandom_range(0, 1));
                default: px_if.out_ready = 1'b0;
            endcase
        end
    end

    // Drives one beat; called just after a rising edge, returns just after
    // the edge that accepted it.
    task automatic send(input logic [7:0] g, input logic sof, input logic md,
                        input logic use_rgb, input logic [23:0] rgb);
        exp_t e;
        int   t;
        px_if.in_gray  = g;
        px_if.in_sof   = sof;
        px_if.in_mode  = md;
        px_if.in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!px_if.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!px_if.in_ready) begin
            check_val("in_ready_timeout", 32'(px_if.in_ready), 32'd1);
        end else begin
            if (sof) begin
                m_col  = 0;
                m_row  = 0;
                m_mode = md;
            end
            e.sof = sof;
            e.eol = (m_col == W - 1);
            e.eof = e.eol && (m_row == H - 1);
            if (e.eol) begin
                m_col = 0;
                m_row = e.eof ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
            e.rgb = use_rgb ? rgb : map_ref(g, m_mode);
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        px_if.in_valid = 1'b0;
        px_if.in_sof   = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check_val("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // output monitor
    logic        prev_stall = 1'b0;
    logic [27:0] prev_word  = '0;
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [27:0] word;
        word = {px_if.out_valid, px_if.out_r, px_if.out_g, px_if.out_b,
                px_if.out_sof, px_if.out_eol, px_if.out_eof};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check_val("stall_hold", 32'(word), 32'(prev_word));
            if (px_if.out_valid && px_if.out_ready) begin
                check_val("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_out++;
                    check_val("rgb", 32'({px_if.out_r, px_if.out_g, px_if.out_b}), 32'(e.rgb));
                    check_val("flags", 32'({px_if.out_sof, px_if.out_eol, px_if.out_eof}),
                              32'({e.sof, e.eol, e.eof}));
                    if (lat_chk) check_val("latency", 32'(cyc - e.cyc), 32'd2);
                    if (px_if.out_sof) n_sof++;
                    if (px_if.out_eof) n_eof++;
                    if (px_if.out_eol) begin
                        n_eol++;
                        last_eol_idx = n_out;
                    end
                end
            end
            prev_stall = px_if.out_valid && !px_if.out_ready;
            prev_word  = word;
        end
    end

    logic [7:0]  heat_g   [8] = '{8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};
    logic [23:0] heat_rgb [8] = '{24'h0000FF, 24'h00FCFF, 24'h00FFFF, 24'h00FF03,
                                  24'h00FF00, 24'hFCFF00, 24'hFFFF00, 24'hFF0300};

    initial begin
        px_if.in_gray  = '0;
        px_if.in_valid = 1'b0;
        px_if.in_sof   = 1'b0;
        px_if.in_mode  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        check_val("rst_out_valid", 32'(px_if.out_valid), 32'd0);
        check_val("rst_rgb", 32'({px_if.out_r, px_if.out_g, px_if.out_b}), 32'd0);
        check_val("rst_flags", 32'({px_if.out_sof, px_if.out_eol, px_if.out_eof}), 32'd0);
        check_val("rst_frame_err", 32'(frame_err), 32'd0);
        check_val("rst_in_ready", 32'(px_if.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // mode 0 sweep
        for (int i = 0; i < 256; i++) send(8'(i), i == 0, 1'b0, 1'b0, 24'h0);
        drain();
        check_val("sweep_count", 32'(n_out), 32'd256);

        // heat map points
        for (int i = 0; i < 8; i++) send(heat_g[i], i == 0, 1'b1, 1'b1, heat_rgb[i]);
        drain();

        // framing
        n_sof = 0; n_eol = 0; n_eof = 0;
        for (int i = 0; i < 16; i++) send(8'(i * 7), (i == 0) || (i == 8), 1'b0, 1'b0, 24'h0);
        drain();
        check_val("frame_n_eol", 32'(n_eol), 32'd4);
        check_val("frame_n_eof", 32'(n_eof), 32'd2);
        check_val("frame_n_sof", 32'(n_sof), 32'd2);
        check_val("frame_err_clean", 32'(frame_err), 32'd0);

        // back-pressure with random gaps
        lat_chk = 1'b0;
        bp_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), i == 0, 1'($urandom_range(0, 1)), 1'b0, 24'h0);
        end
        drain();
        bp_mode = 0;
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        check_val("bp_frame_err", 32'(frame_err), 32'd0);

        // mid-frame sof on beat 3
        n_out = 0; n_eol = 0; last_eol_idx = 0;
        for (int i = 1; i <= 6; i++) send(8'(i), (i == 1) || (i == 3), 1'b0, 1'b0, 24'h0);
        drain();
        check_val("midsof_frame_err", 32'(frame_err), 32'd1);
        check_val("midsof_eol_beat", 32'(last_eol_idx), 32'd6);
        check_val("midsof_n_eol", 32'(n_eol), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check_val("midsof_sticky", 32'(frame_err), 32'd1);

        // reset with both stages full
        bp_mode = 2;
        @(posedge clk);
        #1;
        send(8'd100, 1'b1, 1'b1, 1'b0, 24'h0);
        send(8'd200, 1'b0, 1'b0, 1'b0, 24'h0);
        @(negedge clk);
        check_val("full_in_ready", 32'(px_if.in_ready), 32'd0);
        check_val("full_out_valid", 32'(px_if.out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_col = 0; m_row = 0; m_mode = 1'b0;
        @(negedge clk);
        check_val("mrst_out_valid", 32'(px_if.out_valid), 32'd0);
        check_val("mrst_frame_err", 32'(frame_err), 32'd0);
        check_val("mrst_in_ready", 32'(px_if.in_ready), 32'd1);
        bp_mode = 0;
        @(posedge clk);
        #1;
        n_out = 0; n_sof = 0; n_eol = 0;
        for (int i = 0; i < 8; i++) send(8'(200 + i), 1'b0, 1'b1, 1'b0, 24'h0);
        drain();
        check_val("mrst_beats", 32'(n_out), 32'd8);
        check_val("mrst_no_sof", 32'(n_sof), 32'd0);
        check_val("mrst_n_eol", 32'(n_eol), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
